// File: rtl/sha256_nblock.sv
// sha256_nblock: SHA-256 over 1..max_blocks_p pre-padded blocks, one round per cycle.
// Revision 1.0 - start hash selectable between the standard IV and a caller midstate.
`default_nettype none

module sha256_nblock #(
  parameter int max_blocks_p = 2,
  parameter int cnt_width_p  = $clog2(max_blocks_p + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [512*max_blocks_p-1:0] in,
  input  logic [cnt_width_p-1:0]      num_blocks_i,
  input  logic                        use_iv_i,
  input  logic [255:0]                iv_i,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [255:0]                out,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam logic [2:0] c_s_idle   = 3'd0;
  localparam logic [2:0] c_s_load   = 3'd1;
  localparam logic [2:0] c_s_round  = 3'd2;
  localparam logic [2:0] c_s_update = 3'd3;
  localparam logic [2:0] c_s_done   = 3'd4;

  localparam logic [255:0] c_iv = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [0:63][31:0] c_k = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  logic [2:0]                  r_state;
  logic [2:0]                  w_next;
  logic [512*max_blocks_p-1:0] r_msg;
  logic [512*max_blocks_p-1:0] w_msg_shift;
  logic [cnt_width_p-1:0]      r_rem;
  logic [cnt_width_p-1:0]      w_clamp;
  logic [255:0]                w_start;
  logic [0:7][31:0]            r_h;
  logic [0:7][31:0]            r_v;
  logic [0:7][31:0]            w_hn;
  logic [0:15][31:0]           r_w;
  logic [5:0]                  r_t;
  logic [255:0]                r_out;
  logic [31:0]                 w_t1;
  logic [31:0]                 w_t2;
  logic [31:0]                 w_wn;

  assign w_clamp = (num_blocks_i > cnt_width_p'(max_blocks_p)) ? cnt_width_p'(max_blocks_p) : num_blocks_i;
  assign w_start = use_iv_i ? iv_i : c_iv;
  assign out     = r_out;

  // Consumed blocks are shifted out so the current block always sits in the MSBs.
  if (max_blocks_p > 1) begin : g_multi
    assign w_msg_shift = {r_msg[512*max_blocks_p-513:0], 512'b0};
  end else begin : g_single
    assign w_msg_shift = '0;
  end

  always_comb begin
    w_t1 = r_v[7] + (rotr(r_v[4], 6) ^ rotr(r_v[4], 11) ^ rotr(r_v[4], 25))
         + ((r_v[4] & r_v[5]) ^ (~r_v[4] & r_v[6])) + c_k[r_t] + r_w[0];
    w_t2 = (rotr(r_v[0], 2) ^ rotr(r_v[0], 13) ^ rotr(r_v[0], 22))
         + ((r_v[0] & r_v[1]) ^ (r_v[0] & r_v[2]) ^ (r_v[1] & r_v[2]));
    w_wn = (rotr(r_w[14], 17) ^ rotr(r_w[14], 19) ^ (r_w[14] >> 10)) + r_w[9]
         + (rotr(r_w[1], 7) ^ rotr(r_w[1], 18) ^ (r_w[1] >> 3)) + r_w[0];
    for (int i = 0; i < 8; i++) begin
      w_hn[i] = r_h[i] + r_v[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= c_s_idle;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_s_idle:   if (in_valid) w_next = (w_clamp == '0) ? c_s_done : c_s_load;
      c_s_load:   w_next = c_s_round;
      c_s_round:  if (r_t == 6'd63) w_next = c_s_update;
      c_s_update: w_next = (r_rem == cnt_width_p'(1)) ? c_s_done : c_s_load;
      c_s_done:   if (out_ready) w_next = c_s_idle;
      default:    w_next = c_s_idle;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == c_s_idle) && !rst_i;
    out_valid = (r_state == c_s_done) && !rst_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_out <= '0;
      r_rem <= '0;
      r_t   <= '0;
    end else begin
      case (r_state)
        c_s_idle: begin
          if (in_valid) begin
            r_msg <= in;
            r_rem <= w_clamp;
            r_h   <= w_start;
            if (w_clamp == '0) r_out <= w_start;
          end
        end
        c_s_load: begin
          r_v <= r_h;
          r_w <= r_msg[512*max_blocks_p-1 -: 512];
          r_t <= '0;
        end
        c_s_round: begin
          r_v <= {w_t1 + w_t2, r_v[0], r_v[1], r_v[2], r_v[3] + w_t1, r_v[4], r_v[5], r_v[6]};
          r_w <= {r_w[1:15], w_wn};
          if (r_t != 6'd63) r_t <= r_t + 6'd1;
        end
        c_s_update: begin
          r_h   <= w_hn;
          r_rem <= r_rem - cnt_width_p'(1);
          r_msg <= w_msg_shift;
          if (r_rem == cnt_width_p'(1)) r_out <= w_hn;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sha256_nblock.sv
// tb_sha256_nblock: scoreboard bench for sha256_nblock (digest, latency, back-pressure, reset abort).
// Revision 1.0
`default_nettype none

module tb_sha256_nblock;

  logic          clk = 1'b0;
  logic          rst;
  logic [1023:0] in_msg;
  logic [1:0]    num_blocks;
  logic          use_iv;
  logic [255:0]  iv;
  logic          in_valid;
  logic          in_ready;
  logic [255:0]  out;
  logic          out_valid;
  logic          out_ready;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_rise  = 0;
  int n_out   = 0;
  logic ov_prev = 1'b0;

  logic [255:0] exp_q[$];
  int           lat_q[$];
  int           acc_q[$];

  localparam logic [255:0] c_iv = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] c_k [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [511:0] c_abc   = {32'h61626380, 416'h0, 64'h18};
  localparam logic [511:0] c_empty = {32'h80000000, 480'h0};
  localparam logic [511:0] c_nist0 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] c_nist1 = {448'h0, 64'h1c0};

  localparam logic [255:0] c_d_abc   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] c_d_nist  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] c_d_empty = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] c_iv_user = 256'h0123456789abcdef0123456789abcdef0123456789abcdef0123456789abcdef;

  sha256_nblock #(.max_blocks_p(2)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in           (in_msg),
    .num_blocks_i (num_blocks),
    .use_iv_i     (use_iv),
    .iv_i         (iv),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out          (out),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (out_valid && out_ready) n_out <= n_out + 1;
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + c_k[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {a + hin[255:224], b + hin[223:192], c + hin[191:160], d + hin[159:128],
            e + hin[127:96],  f + hin[95:64],   g + hin[63:32],   h + hin[31:0]};
  endfunction

  function automatic logic [1023:0] rand_msg();
    logic [1023:0] m;
    for (int i = 0; i < 32; i++) m[32*i +: 32] = $urandom;
    return m;
  endfunction

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Digest and latency are judged when out_valid rises; the queue holds the pending expectations.
  always @(negedge clk) begin
    if (out_valid && !ov_prev) begin
      n_rise++;
      if (exp_q.size() == 0) begin
        check("unexpected_digest", 256'(1), 256'(0));
      end else begin
        logic [255:0] e;
        int l, a;
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        a = acc_q.pop_front();
        check("digest", out, e);
        check("latency", 256'(cyc - a), 256'(l));
      end
    end
    ov_prev = out_valid;
  end

  task automatic send(input logic [1023:0] msg, input logic [1:0] n, input logic uiv,
                      input logic [255:0] ivv, input logic [255:0] exp_d);
    int guard = 0;
    int n_eff;
    n_eff = (n > 2'd2) ? 2 : int'(n);
    @(negedge clk);
    in_msg = msg; num_blocks = n; use_iv = uiv; iv = ivv; in_valid = 1'b1;
    while (!in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check("accept_timeout", 256'(0), 256'(1));
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(exp_d);
    lat_q.push_back(66 * n_eff);
    acc_q.push_back(cyc + 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_msg = rand_msg(); num_blocks = 2'($urandom); use_iv = 1'($urandom); iv = rand_msg()[255:0];
  endtask

  task automatic wait_rise(input int target);
    int guard = 0;
    while (n_rise < target && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (n_rise < target) check("out_timeout", 256'(n_rise), 256'(target));
  endtask

  initial begin
    logic [255:0] mid;
    logic [1023:0] m;
    logic [255:0] st;
    logic [255:0] e;
    logic [1:0] n;
    logic u;
    int base;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_msg = '0; num_blocks = '0; use_iv = 1'b0; iv = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 256'(in_ready), 256'(0));
    check("rst_out_valid", 256'(out_valid), 256'(0));
    check("rst_out", out, 256'(0));
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 256'(in_ready), 256'(1));

    send({c_abc, 512'h0}, 2'd1, 1'b0, '0, c_d_abc);
    wait_rise(1);
    send({c_nist0, c_nist1}, 2'd2, 1'b0, '0, c_d_nist);
    wait_rise(2);
    send({c_nist0, c_nist1}, 2'd3, 1'b0, '0, c_d_nist);
    wait_rise(3);
    mid = compress(c_iv, c_nist0);
    send({c_nist1, 512'h0}, 2'd1, 1'b1, mid, c_d_nist);
    wait_rise(4);
    send({c_empty, 512'h0}, 2'd1, 1'b0, '0, c_d_empty);
    wait_rise(5);
    send(rand_msg(), 2'd0, 1'b1, c_iv_user, c_iv_user);
    wait_rise(6);

    for (int i = 0; i < 3; i++) begin
      m = rand_msg(); n = 2'($urandom_range(1, 3)); u = 1'($urandom); st = u ? mid : c_iv;
      e = st;
      for (int b = 0; b < ((n > 2'd2) ? 2 : int'(n)); b++) e = compress(e, m[1023-512*b -: 512]);
      send(m, n, u, mid, e);
      wait_rise(7 + i);
    end

    // Back-pressure: digest must hold while the consumer stalls.
    out_ready = 1'b0;
    send({c_abc, 512'h0}, 2'd1, 1'b0, '0, c_d_abc);
    wait_rise(10);
    base = n_out;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_out_valid", 256'(out_valid), 256'(1));
      check("bp_out", out, c_d_abc);
      check("bp_in_ready", 256'(in_ready), 256'(0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", 256'(in_ready), 256'(1));
    check("bp_release_valid", 256'(out_valid), 256'(0));
    repeat (5) @(negedge clk);
    check("bp_one_digest", 256'(n_out - base), 256'(1));

    // Abort mid-hash: reset lands on round 30.
    send({c_abc, 512'h0}, 2'd1, 1'b0, '0, c_d_abc);
    repeat (31) @(negedge clk);
    rst = 1'b1;
    exp_q.delete(); lat_q.delete(); acc_q.delete();
    repeat (2) @(negedge clk);
    check("abort_rst_in_ready", 256'(in_ready), 256'(0));
    check("abort_rst_out_valid", 256'(out_valid), 256'(0));
    rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 256'(in_ready), 256'(1));
    repeat (80) @(negedge clk);
    check("abort_no_digest", 256'(n_rise), 256'(10));
    send({c_abc, 512'h0}, 2'd1, 1'b0, '0, c_d_abc);
    wait_rise(11);
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 256'(exp_q.size()), 256'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
